// File: rtl/cpu_harness_pkg.sv
// Shared types and helpers for the cpu load/run/readback harness controller.
// Holds the FSM state encoding, the default stop opcode and the byte-shift field extractor.
package cpu_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    RB_REQ,
    RB_WAIT,
    RB_OUT,
    DONE
  } state_t;

  localparam logic [6:0] STOP_OPC_DEF = 7'h7E;

  // Packed 3-bit shift per channel, channel 0 in the LSBs; up to 8 channels.
  function automatic logic [2:0] bshift(input logic [23:0] fields, input int unsigned c);
    return fields[c*3 +: 3];
  endfunction

endpackage

// File: rtl/cpu_harness_ctrl.sv
// Preload N_CH memories from a valid/ready stream, run the cpu until STOP or timeout, stream a result window out.
// Writes land 1 cycle after the in_* handshake; readback costs >= 3 cycles/word and holds rb_* while rb_ready is low.
module cpu_harness_ctrl
  import cpu_harness_pkg::*;
#(
  parameter int unsigned         N_CH       = 2,
  parameter int unsigned         DATA_W     = 64,
  parameter int unsigned         ADDR_W     = 64,
  parameter int unsigned         LOAD_LEN   = 128,
  parameter logic [3*N_CH-1:0]   BYTE_SHIFT = {3'd3, 3'd2},
  parameter logic [6:0]          STOP_OPC   = STOP_OPC_DEF,
  parameter int unsigned         TIMEOUT    = 99999,
  parameter int unsigned         RB_CH      = 1,
  parameter int unsigned         RB_LEN     = 47
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH-1:0]        mem_wen,
  output logic [N_CH-1:0]        mem_ren,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [N_CH*DATA_W-1:0] mem_rdata,
  output logic                   cpu_enable,
  input  logic [31:0]            instr,
  output logic                   rb_valid,
  input  logic                   rb_ready,
  output logic [DATA_W-1:0]      rb_data,
  output logic                   rb_last,
  output logic                   done,
  output logic                   timed_out,
  output logic [3:0]             test_id,
  output logic [31:0]            cycles
);

  localparam int unsigned IDX_W = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned RB_W  = (RB_LEN > 1) ? $clog2(RB_LEN) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [RB_W-1:0]  LAST_RB  = RB_W'(RB_LEN - 1);
  localparam logic [2:0]       RB_SHIFT = bshift(24'(BYTE_SHIFT), RB_CH);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ld_idx;
  logic [CH_W-1:0]    ld_ch;
  logic               load_full;
  logic [RB_W-1:0]    rb_idx;
  logic [N_CH-1:0]    wen_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rb_data_q;
  logic [31:0]        cycles_q;
  logic [31:0]        cycles_nxt;
  logic [3:0]         test_id_q;
  logic               timed_out_q;
  logic               hs;
  logic               is_stop;
  logic               is_tmo;
  logic               restart;
  logic               unused_bits;

  assign unused_bits = ^{instr[27:7], mem_rdata};

  assign cycles_nxt = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
  assign is_stop    = (instr[6:0] == STOP_OPC);
  assign is_tmo     = (cycles_nxt > 32'(TIMEOUT));
  assign hs         = in_valid && in_ready;
  assign restart    = start && ((state == IDLE) || (state == DONE));

  assign mem_wen    = wen_q;
  assign mem_wdata  = wdata_q;
  assign rb_data    = rb_data_q;
  assign cycles     = cycles_q;
  assign test_id    = test_id_q;
  assign timed_out  = timed_out_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    mem_ren    = '0;
    mem_addr   = '0;
    cpu_enable = 1'b0;
    rb_valid   = 1'b0;
    rb_last    = 1'b0;
    done       = 1'b0;
    if (|wen_q) begin
      mem_addr = waddr_q;
    end
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = !load_full;
        // Leave only once the final registered write has been presented.
        if (load_full) state_nxt = SETTLE;
      end
      SETTLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        cpu_enable = 1'b1;
        if (is_stop || is_tmo) state_nxt = RB_REQ;
      end
      RB_REQ: begin
        mem_ren   = N_CH'(1) << RB_CH;
        mem_addr  = ADDR_W'(rb_idx) << RB_SHIFT;
        state_nxt = RB_WAIT;
      end
      RB_WAIT: begin
        state_nxt = RB_OUT;
      end
      RB_OUT: begin
        rb_valid = 1'b1;
        rb_last  = (rb_idx == LAST_RB);
        if (rb_ready) state_nxt = (rb_idx == LAST_RB) ? DONE : RB_REQ;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ld_idx      <= '0;
      ld_ch       <= '0;
      load_full   <= 1'b0;
      rb_idx      <= '0;
      wen_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rb_data_q   <= '0;
      cycles_q    <= '0;
      test_id_q   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wen_q <= '0;
      if (restart) begin
        ld_idx      <= '0;
        ld_ch       <= '0;
        load_full   <= 1'b0;
        rb_idx      <= '0;
        cycles_q    <= '0;
        test_id_q   <= '0;
        timed_out_q <= 1'b0;
      end
      if (hs) begin
        wen_q   <= N_CH'(1) << ld_ch;
        waddr_q <= ADDR_W'(ld_idx) << bshift(24'(BYTE_SHIFT), 32'(ld_ch));
        wdata_q <= in_data;
        if (ld_idx == LAST_IDX) begin
          ld_idx <= '0;
          if (ld_ch == LAST_CH) begin
            load_full <= 1'b1;
          end else begin
            ld_ch <= ld_ch + 1'b1;
          end
        end else begin
          ld_idx <= ld_idx + 1'b1;
        end
      end
      if (state == SETTLE) begin
        cycles_q <= '0;
      end
      if (state == RUN) begin
        cycles_q <= cycles_nxt;
        // STOP takes priority over a timeout landing on the same cycle.
        if (is_stop) begin
          test_id_q <= instr[31:28];
        end else if (is_tmo) begin
          timed_out_q <= 1'b1;
        end
      end
      if (state == RB_WAIT) begin
        rb_data_q <= mem_rdata[RB_CH*DATA_W +: DATA_W];
      end
      if ((state == RB_OUT) && rb_ready && (rb_idx != LAST_RB)) begin
        rb_idx <= rb_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_harness_ctrl.sv
// Directed bench for cpu_harness_ctrl: vector table for the load phase plus hand sequences for run/readback/reset.
module tb_cpu_harness_ctrl;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  mem_wen;
  logic [1:0]  mem_ren;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_enable;
  logic [31:0] instr;
  logic        rb_valid;
  logic        rb_ready;
  logic [15:0] rb_data;
  logic        rb_last;
  logic        done;
  logic        timed_out;
  logic [3:0]  test_id;
  logic [31:0] cycles;

  int n_vec;
  int n_err;

  logic [15:0] rb_mem [4];
  logic [15:0] rd1;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        exp_rdy;
    logic [1:0]  exp_wen;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_cpu;
  } vec_t;

  vec_t tbl [11];

  cpu_harness_ctrl #(
    .N_CH(2), .DATA_W(16), .ADDR_W(16), .LOAD_LEN(4), .BYTE_SHIFT(6'b011_010),
    .STOP_OPC(7'h7E), .TIMEOUT(50), .RB_CH(1), .RB_LEN(3)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_enable(cpu_enable), .instr(instr),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data), .rb_last(rb_last),
    .done(done), .timed_out(timed_out), .test_id(test_id), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: read data appears one cycle after mem_ren, word index = addr >> 3.
  assign mem_rdata = {rd1, 16'h0000};
  always @(posedge clk) if (mem_ren[1]) rd1 <= rb_mem[mem_addr[4:3]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {in_ready, mem_wen, mem_ren, mem_addr, mem_wdata, cpu_enable, rb_valid,
             rb_data, rb_last, done, timed_out, test_id, cycles}, '0);
  endtask

  // Enter with the DUT in LOAD; feeds 8 words (optionally with gaps) and returns in the first RUN cycle.
  task automatic load_and_run(input bit gaps, input logic [15:0] base);
    int hs;
    int nw;
    logic [15:0] ea;
    hs = 0;
    nw = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = gaps ? (i % 2 == 0) : (hs < 8);
      in_data  = base + 16'(hs);
      if (in_valid && in_ready) hs++;
      step();
      if (mem_wen != 2'b00) begin
        ea = (nw < 4) ? 16'(nw * 4) : 16'((nw - 4) * 8);
        chk("load_wen", mem_wen, (nw < 4) ? 2'b01 : 2'b10);
        chk("load_addr", mem_addr, ea);
        chk("load_wdata", mem_wdata, base + 16'(nw));
        chk("load_no_ren", mem_ren, 2'b00);
        nw++;
      end
      if (cpu_enable) break;
    end
    in_valid = 1'b0;
    chk("load_write_count", nw, 8);
    chk("run_entered", cpu_enable, 1'b1);
    chk("run_cycles_start", cycles, 0);
  endtask

  // Enter in RB_REQ; checks request, wait, presentation and optional stall, then accepts the word.
  task automatic rb_word(input logic [15:0] ea, input logic [15:0] ed, input logic el, input int stall);
    chk("rb_ren", mem_ren, 2'b10);
    chk("rb_addr", mem_addr, ea);
    chk("rb_no_wen", mem_wen, 2'b00);
    rb_ready = 1'b0;
    step();
    chk("rb_wait_valid", rb_valid, 1'b0);
    chk("rb_wait_ren", mem_ren, 2'b00);
    step();
    chk("rb_valid", rb_valid, 1'b1);
    chk("rb_data", rb_data, ed);
    chk("rb_last", rb_last, el);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("rb_stall_valid", rb_valid, 1'b1);
      chk("rb_stall_data", rb_data, ed);
      chk("rb_stall_last", rb_last, el);
      chk("rb_stall_ren", mem_ren, 2'b00);
    end
    rb_ready = 1'b1;
    step();
    rb_ready = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    arst_n   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    instr    = '0;
    rb_ready = 1'b0;
    rb_mem[0] = 16'h0258;
    rb_mem[1] = 16'h02B2;
    rb_mem[2] = 16'h030C;
    rb_mem[3] = 16'h0000;

    #3;
    chk_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    arst_n = 1'b1;

    // start, 8 back-to-back words, SETTLE, first RUN cycle
    tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b1, 2'b00, 16'd0,  16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'd1, 1'b1, 2'b01, 16'd0,  16'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'd2, 1'b1, 2'b01, 16'd4,  16'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'd3, 1'b1, 2'b01, 16'd8,  16'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'd4, 1'b1, 2'b01, 16'd12, 16'd4, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'd5, 1'b1, 2'b10, 16'd0,  16'd5, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'd6, 1'b1, 2'b10, 16'd8,  16'd6, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'd7, 1'b1, 2'b10, 16'd16, 16'd7, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'd8, 1'b0, 2'b10, 16'd24, 16'd8, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 16'd0,  16'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 16'd0,  16'd0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].in_valid;
      in_data  = tbl[i].in_data;
      step();
      start = 1'b0;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      chk($sformatf("vec%0d_wen", i), mem_wen, tbl[i].exp_wen);
      chk($sformatf("vec%0d_ren", i), mem_ren, 2'b00);
      chk($sformatf("vec%0d_cpu_enable", i), cpu_enable, tbl[i].exp_cpu);
      if (tbl[i].exp_wen != 2'b00) begin
        chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].exp_addr);
        chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].exp_wdata);
      end
    end
    in_valid = 1'b0;
    chk("run1_cycles", cycles, 0);

    // STOP on run cycle 20; a start pulse mid-run must be ignored
    for (int i = 1; i < 20; i++) begin
      instr = 32'h0;
      start = (i == 5);
      step();
      start = 1'b0;
    end
    chk("run19_cycles", cycles, 19);
    chk("run19_cpu_enable", cpu_enable, 1'b1);
    instr = 32'h1000007E;
    step();
    instr = 32'h0;
    chk("stop_cpu_enable", cpu_enable, 1'b0);
    chk("stop_test_id", test_id, 4'd1);
    chk("stop_cycles", cycles, 20);
    chk("stop_timed_out", timed_out, 1'b0);
    chk("stop_done", done, 1'b0);

    rb_word(16'd0,  16'h0258, 1'b0, 0);
    rb_word(16'd8,  16'h02B2, 1'b0, 5);
    rb_word(16'd16, 16'h030C, 1'b1, 0);
    chk("rb_done", done, 1'b1);
    chk("rb_done_valid", rb_valid, 1'b0);
    step();
    chk("done_hold", done, 1'b1);
    chk("done_hold_cycles", cycles, 20);
    chk("done_hold_test_id", test_id, 4'd1);

    // restart from DONE with a gappy preload, then let it time out
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done", done, 1'b0);
    chk("restart_cycles", cycles, 0);
    chk("restart_test_id", test_id, 4'd0);
    chk("restart_in_ready", in_ready, 1'b1);
    load_and_run(1'b1, 16'h0100);
    repeat (50) step();
    chk("tmo50_cpu_enable", cpu_enable, 1'b1);
    chk("tmo50_cycles", cycles, 50);
    step();
    chk("tmo_cpu_enable", cpu_enable, 1'b0);
    chk("tmo_timed_out", timed_out, 1'b1);
    chk("tmo_test_id", test_id, 4'd0);
    chk("tmo_cycles", cycles, 51);
    rb_word(16'd0,  16'h0258, 1'b0, 0);
    rb_word(16'd8,  16'h02B2, 1'b0, 0);
    rb_word(16'd16, 16'h030C, 1'b1, 0);
    chk("tmo_done", done, 1'b1);
    chk("tmo_done_timed_out", timed_out, 1'b1);

    // STOP on the cycle that would also time out
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart2_timed_out", timed_out, 1'b0);
    load_and_run(1'b0, 16'h0300);
    repeat (50) step();
    instr = 32'h3000007E;
    step();
    instr = 32'h0;
    chk("both_timed_out", timed_out, 1'b0);
    chk("both_test_id", test_id, 4'd3);
    chk("both_cycles", cycles, 51);
    chk("both_cpu_enable", cpu_enable, 1'b0);

    // reset while a readback word is being presented
    step();
    step();
    chk("pre_reset_rb_valid", rb_valid, 1'b1);
    #2 arst_n = 1'b0;
    #1 chk_zero("reset_mid_readback");
    #1 arst_n = 1'b1;
    step();
    chk_zero("idle_after_reset");

    start = 1'b1;
    step();
    start = 1'b0;
    chk("reload_in_ready", in_ready, 1'b1);
    load_and_run(1'b0, 16'h0400);
    repeat (5) step();
    chk("run5_cycles", cycles, 5);
    #2 arst_n = 1'b0;
    #1 chk_zero("reset_mid_run");
    #1 arst_n = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("final_done", done, 1'b0);
    load_and_run(1'b0, 16'h0500);
    instr = 32'h1000007E;
    step();
    instr = 32'h0;
    chk("final_cycles", cycles, 1);
    chk("final_test_id", test_id, 4'd1);
    chk("final_cpu_enable", cpu_enable, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
